// File: rtl/bcd_seg_feed.sv
// Binary-to-two-digit 7-segment feeder: sequential double-dabble, one bit per clock, with a one-deep pending buffer.
// Optional macro BLANK_LEAD_ZERO_EN blanks a zero tens digit (and the tens digit at reset).
module bcd_seg_feed #(
  parameter int W = 7
) (
  input  logic         clk_1khz,
  input  logic         rst,
  input  logic [W-1:0] value,
  input  logic         value_vld,
  output logic [6:0]   seg_code,
  output logic [6:0]   seg_code1,
  output logic         busy,
  output logic         ovf
);

  // value_vld is a single-cycle strobe; value is captured on the edge where it is high.
  // Strobes that arrive during SHIFT or DONE go to the pending buffer (latest wins).

  localparam logic [6:0] SEG_ZERO  = 7'b1111110;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
`ifdef BLANK_LEAD_ZERO_EN
  localparam logic [6:0] SEG1_RST = SEG_BLANK;
`else
  localparam logic [6:0] SEG1_RST = SEG_ZERO;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] bin_q, bin_d;
  logic [11:0]  bcd_q, bcd_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_val_q, pend_val_d;
  logic [6:0]   seg_q, seg_d;
  logic [6:0]   seg1_q, seg1_d;
  logic         busy_q, busy_d;
  logic         ovf_q, ovf_d;

  logic [11:0]   bcd_adj;
  logic [W+11:0] shifted;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    seg_d      = seg_q;
    seg1_d     = seg1_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (value_vld) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = 4'(W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[W+11:W];
        bin_d = shifted[W-1:0];
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
        if (value_vld) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
      end
      DONE: begin
        if (bcd_q[11:8] != 4'd0) begin
          ovf_d  = 1'b1;
          seg_d  = SEG_DASH;
          seg1_d = SEG_DASH;
        end else begin
          ovf_d  = 1'b0;
          seg_d  = seg7(bcd_q[3:0]);
          seg1_d = seg7(bcd_q[7:4]);
`ifdef BLANK_LEAD_ZERO_EN
          if (bcd_q[7:4] == 4'd0) seg1_d = SEG_BLANK;
`endif
        end
        // A strobe on this very edge beats whatever is pending; either way the buffer is consumed.
        if (value_vld || pend_q) begin
          bin_d   = value_vld ? value : pend_val_q;
          bcd_d   = '0;
          cnt_d   = 4'(W);
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      seg_q      <= SEG_ZERO;
      seg1_q     <= SEG1_RST;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      seg_q      <= seg_d;
      seg1_q     <= seg1_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign seg_code  = seg_q;
  assign seg_code1 = seg1_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_seg_feed.sv
// Self-checking bench for bcd_seg_feed: vector table, hand-timed corner sequences, random values vs. a decimal model.
module tb_bcd_seg_feed;
  localparam int W = 7;
  localparam logic [6:0] DASH = 7'b0000001;
  localparam logic [6:0] ZERO = 7'b1111110;
`ifdef BLANK_LEAD_ZERO_EN
  localparam logic [6:0] T0 = 7'b0000000;
`else
  localparam logic [6:0] T0 = 7'b1111110;
`endif

  logic         clk_1khz;
  logic         rst;
  logic [W-1:0] value;
  logic         value_vld;
  logic [6:0]   seg_code, seg_code1;
  logic         busy, ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_q[$];
  logic [14:0] shown;
  logic [6:0]  seg_tab[10];

  bcd_seg_feed #(.W(W)) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .value    (value),
    .value_vld(value_vld),
    .seg_code (seg_code),
    .seg_code1(seg_code1),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  typedef struct {
    int         v;
    logic       e_ovf;
    logic [6:0] e_seg1;
    logic [6:0] e_seg;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference: {ovf, tens segments, units segments}.
  function automatic logic [14:0] model(input int v);
    logic [6:0] t;
    if (v > 99) return {1'b1, DASH, DASH};
    t = seg_tab[v / 10];
`ifdef BLANK_LEAD_ZERO_EN
    if (v / 10 == 0) t = 7'b0000000;
`endif
    return {1'b0, t, seg_tab[v % 10]};
  endfunction

  function automatic logic [14:0] outs();
    return {ovf, seg_code1, seg_code};
  endfunction

  // Called #1 after a posedge; checks busy, hold-until-DONE and exact 9-clock latency.
  task automatic conv(input int v, input string name);
    logic [14:0] e;
    value = W'(v);
    value_vld = 1'b1;
    @(posedge clk_1khz); #1;
    value_vld = 1'b0;
    check({name, "_busy_rise"}, 16'(busy), 16'd1);
    repeat (W) @(posedge clk_1khz);
    #1;
    check({name, "_hold"}, 16'(outs()), 16'(shown));
    check({name, "_busy_mid"}, 16'(busy), 16'd1);
    @(posedge clk_1khz); #1;
    e = exp_q.pop_front();
    check({name, "_result"}, 16'(outs()), 16'(e));
    check({name, "_busy_fall"}, 16'(busy), 16'd0);
    shown = e;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  initial begin
    vec_t vecs[9];
    logic [14:0] e;
    int r;
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    vecs[0] = '{42,  1'b0, 7'b0110011, 7'b1101101};
    vecs[1] = '{99,  1'b0, 7'b1111011, 7'b1111011};
    vecs[2] = '{100, 1'b1, DASH, DASH};
    vecs[3] = '{127, 1'b1, DASH, DASH};
    vecs[4] = '{0,   1'b0, T0, ZERO};
    vecs[5] = '{5,   1'b0, T0, 7'b1011011};
    vecs[6] = '{9,   1'b0, T0, 7'b1111011};
    vecs[7] = '{10,  1'b0, 7'b0110000, ZERO};
    vecs[8] = '{57,  1'b0, 7'b1011011, 7'b1110000};

    rst = 1'b1; value = '0; value_vld = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(5);
    shown = {1'b0, T0, ZERO};
    check("reset_outs", 16'(outs()), 16'(shown));
    check("reset_busy", 16'(busy), 16'd0);

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vecs[i].e_ovf, vecs[i].e_seg1, vecs[i].e_seg});
      conv(vecs[i].v, $sformatf("vec%0d", vecs[i].v));
      idle(1);
    end

    // 12, 34, 56 back to back: 12 shown, 56 relaunched from DONE, 34 dropped.
    value = 7'd12; value_vld = 1'b1; idle(1);
    value = 7'd34; idle(1);
    value = 7'd56; idle(1);
    value_vld = 1'b0;
    idle(5);
    check("b2b_hold12", 16'(outs()), 16'(shown));
    idle(1);
    check("b2b_show12", 16'(outs()), 16'(model(12)));
    idle(7);
    check("b2b_no34", 16'(outs()), 16'(model(12)));
    check("b2b_busy", 16'(busy), 16'd1);
    idle(1);
    check("b2b_show56", 16'(outs()), 16'(model(56)));
    check("b2b_idle", 16'(busy), 16'd0);
    shown = model(56);
    idle(2);

    // Strobe landing on the DONE edge relaunches with that value.
    value = 7'd23; value_vld = 1'b1; idle(1);
    value_vld = 1'b0; idle(7);
    value = 7'd45; value_vld = 1'b1; idle(1);
    value_vld = 1'b0;
    check("done_strobe_23", 16'(outs()), 16'(model(23)));
    idle(8);
    check("done_strobe_45", 16'(outs()), 16'(model(45)));
    shown = model(45);
    idle(2);

    // Reset in the middle of converting 88 discards it.
    value = 7'd88; value_vld = 1'b1; idle(1);
    value_vld = 1'b0; idle(2);
    rst = 1'b1; idle(1);
    rst = 1'b0;
    shown = {1'b0, T0, ZERO};
    check("midrst_outs", 16'(outs()), 16'(shown));
    check("midrst_busy", 16'(busy), 16'd0);
    idle(12);
    check("midrst_no_update", 16'(outs()), 16'(shown));
    check("midrst_busy_late", 16'(busy), 16'd0);
    exp_q.push_back({1'b0, T0, 7'b1110000});
    conv(7, "after_rst7");
    idle(1);

    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, (1 << W) - 1);
      e = model(r);
      exp_q.push_back(e);
      conv(r, $sformatf("rnd%0d", r));
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
